// File: rtl/mdu_unit_if.sv
// Operand, control and result bundle between the pipeline and the multiply/divide unit.
// The pipeline drives operands and requests; the unit returns HI/LO and its occupancy.
interface mdu_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Cancel;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Occupied;

  modport master (
    output A, B, MDOp, Start, Cancel,
    input  HI, LO, Busy, Occupied
  );

  modport slave (
    input  A, B, MDOp, Start, Cancel,
    output HI, LO, Busy, Occupied
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// The result is computed when the request is accepted and held back until the busy window ends.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] temp_hi_r;
  logic [31:0] temp_lo_r;
  logic        busy_r;

  logic        sgn_s;
  logic [63:0] opa_s;
  logic [63:0] opb_s;
  logic [63:0] prod_s;
  logic [31:0] dvd_s;
  logic [31:0] dvs_s;
  logic [31:0] quo_mag_s;
  logic [31:0] rem_mag_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [63:0] res_s;

  // Shared multiplier and sign-magnitude divider producing the 64-bit {HI,LO} candidate
  always_comb begin
    sgn_s  = (bus.MDOp == 3'b000) || (bus.MDOp == 3'b010);
    opa_s  = {{32{sgn_s & bus.A[31]}}, bus.A};
    opb_s  = {{32{sgn_s & bus.B[31]}}, bus.B};
    prod_s = opa_s * opb_s;
    dvd_s  = (sgn_s && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    dvs_s  = (sgn_s && bus.B[31]) ? (32'd0 - bus.B) : bus.B;
    if (dvs_s == 32'd0) begin
      dvs_s = 32'd1;
    end else begin
      dvs_s = dvs_s;
    end
    quo_mag_s = dvd_s / dvs_s;
    rem_mag_s = dvd_s % dvs_s;
    // Quotient truncates toward zero; remainder follows the dividend's sign
    quo_s = (sgn_s && (bus.A[31] ^ bus.B[31])) ? (32'd0 - quo_mag_s) : quo_mag_s;
    rem_s = (sgn_s && bus.A[31]) ? (32'd0 - rem_mag_s) : rem_mag_s;
    case (bus.MDOp)
      3'b000, 3'b001: res_s = prod_s;
      3'b010, 3'b011: begin
        if (bus.B == 32'd0) begin
          res_s = {hi_r, lo_r};
        end else begin
          res_s = {rem_s, quo_s};
        end
      end
      default: res_s = {hi_r, lo_r};
    endcase
  end

  // Control FSM, busy countdown and HI/LO commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      temp_hi_r <= 32'd0;
      temp_lo_r <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.Start && !bus.Cancel) begin
            case (bus.MDOp)
              3'b000, 3'b001: begin
                temp_hi_r <= res_s[63:32];
                temp_lo_r <= res_s[31:0];
                cnt_r     <= MULT_N;
                state_r   <= RUN;
                busy_r    <= 1'b1;
              end
              3'b010, 3'b011: begin
                temp_hi_r <= res_s[63:32];
                temp_lo_r <= res_s[31:0];
                cnt_r     <= DIV_N;
                state_r   <= RUN;
                busy_r    <= 1'b1;
              end
              3'b100:  hi_r <= bus.A;
              3'b101:  lo_r <= bus.A;
              default: state_r <= IDLE;
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (bus.Cancel) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            cnt_r     <= 4'd0;
            temp_hi_r <= 32'd0;
            temp_lo_r <= 32'd0;
          end else if (cnt_r == 4'd1) begin
            hi_r    <= temp_hi_r;
            lo_r    <= temp_lo_r;
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.HI       = hi_r;
  assign bus.LO       = lo_r;
  assign bus.Busy     = busy_r;
  assign bus.Occupied = bus.Start | busy_r;

endmodule
